// File: rtl/csr_file.sv
// csr_file: LoongArch CSR file with exception/ERTN state handling, constant timer and interrupt request.
module csr_file (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);
  localparam logic [13:0] CRMD = 14'h0, PRMD = 14'h1, ECFG = 14'h4, ESTAT = 14'h5, ERA = 14'h6;
  localparam logic [13:0] BADV = 14'h7, EENTRY = 14'hC, SAVE0 = 14'h30, TID = 14'h40;
  localparam logic [13:0] TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;
  logic [2:0]       crmd_q, crmd_d, prmd_q, prmd_d;
  logic [12:0]      lie_q, lie_d;
  logic [1:0]       is_sw_q, is_sw_d;
  logic [7:0]       is_hw_q;
  logic             is_ti_q, is_ti_d, is_ipi_q, ti_set, sw_we;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d, badv_q, badv_d, tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [3:0][31:0] save_q, save_d;
  logic [31:0]      keep, wm, rdata;
  logic [12:0]      is_v;
  assign sw_we = csr_we & ~wb_ex & ~ertn_flush;
  assign keep  = ~csr_wmask;
  assign wm    = csr_wvalue & csr_wmask;
  assign is_v  = {is_ipi_q, is_ti_q, 1'b0, is_hw_q, is_sw_q};
  always_comb begin
    crmd_d   = wb_ex ? 3'd0 : ertn_flush ? prmd_q :
               (sw_we && csr_num == CRMD) ? (crmd_q & keep[2:0]) | wm[2:0] : crmd_q;
    prmd_d   = wb_ex ? crmd_q : (sw_we && csr_num == PRMD) ? (prmd_q & keep[2:0]) | wm[2:0] : prmd_q;
    lie_d    = (sw_we && csr_num == ECFG) ? ((lie_q & keep[12:0]) | wm[12:0]) & 13'h1BFF : lie_q;
    is_sw_d  = (sw_we && csr_num == ESTAT) ? (is_sw_q & keep[1:0]) | wm[1:0] : is_sw_q;
    ecode_d  = wb_ex ? wb_ecode : ecode_q;
    esub_d   = wb_ex ? wb_esubcode : esub_q;
    era_d    = wb_ex ? wb_pc : (sw_we && csr_num == ERA) ? (era_q & keep) | wm : era_q;
    badv_d   = (wb_ex && wb_ecode == 6'h8) ? wb_pc : (wb_ex && wb_ecode == 6'h9) ? wb_vaddr :
               (sw_we && csr_num == BADV) ? (badv_q & keep) | wm : badv_q;
    eentry_d = (sw_we && csr_num == EENTRY) ? (eentry_q & keep[31:6]) | wm[31:6] : eentry_q;
    for (int k = 0; k < 4; k++)
      save_d[k] = (sw_we && csr_num == SAVE0 + 14'(k)) ? (save_q[k] & keep) | wm : save_q[k];
    tid_d    = (sw_we && csr_num == TID) ? (tid_q & keep) | wm : tid_q;
    tcfg_d   = (sw_we && csr_num == TCFG) ? (tcfg_q & keep) | wm : tcfg_q;
    // a TCFG write that leaves the timer enabled restarts the count, pre-empting this cycle's tick
    ti_set   = 1'b0;
    tval_d   = tval_q;
    if (sw_we && csr_num == TCFG && tcfg_d[0])
      tval_d = {tcfg_d[31:2], 2'b00};
    else if (tcfg_q[0] && tval_q != '1) begin
      ti_set = tval_q == '0;
      tval_d = (tval_q != '0) ? tval_q - 32'd1 : tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : '1;
    end
    is_ti_d  = ti_set | (is_ti_q & ~(sw_we && csr_num == TICLR && wm[0]));
  end
  always_comb begin
    rdata = '0;
    case (csr_num)
      CRMD:          rdata = {28'd0, 1'b1, crmd_q};
      PRMD:          rdata = {29'd0, prmd_q};
      ECFG:          rdata = {19'd0, lie_q};
      ESTAT:         rdata = {1'b0, esub_q, ecode_q, 3'd0, is_v};
      ERA:           rdata = era_q;
      BADV:          rdata = badv_q;
      EENTRY:        rdata = {eentry_q, 6'd0};
      14'h30:        rdata = save_q[0];
      14'h31:        rdata = save_q[1];
      14'h32:        rdata = save_q[2];
      14'h33:        rdata = save_q[3];
      TID:           rdata = tid_q;
      TCFG:          rdata = tcfg_q;
      TVAL:          rdata = tval_q;
      default:       rdata = '0;
    endcase
  end
  assign csr_rvalue = csr_re ? rdata : '0;
  assign ex_entry   = {eentry_q, 6'd0};
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[2] & |(is_v & lie_q);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q   <= '0;
      prmd_q   <= '0;
      lie_q    <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      is_ti_q  <= 1'b0;
      is_ipi_q <= 1'b0;
      ecode_q  <= '0;
      esub_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      save_q   <= '0;
      tid_q    <= '0;
      tcfg_q   <= '0;
      tval_q   <= '1;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      lie_q    <= lie_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= hw_int_in;
      is_ti_q  <= is_ti_d;
      is_ipi_q <= ipi_int_in;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: vector table, directed exception/timer/interrupt sequences and a random run against a word-level model.
module tb_csr_file;
  logic        clk = 0, resetn = 0, csr_re = 0, csr_we = 0, wb_ex = 0, ertn_flush = 0, ipi_int_in = 0;
  logic [13:0] csr_num = 0;
  logic [31:0] csr_rvalue, csr_wmask = 0, csr_wvalue = 0, wb_pc = 0, wb_vaddr = 0, ex_entry, ertn_entry;
  logic [5:0]  wb_ecode = 0;
  logic [8:0]  wb_esubcode = 0;
  logic [7:0]  hw_int_in = 0;
  logic        has_int;
  int          errors = 0, checks = 0;

  csr_file dut (.clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int));

  always #5 clk = ~clk;

  // reference model: one 32-bit word per CSR address, updated with the architectural rules
  logic [31:0] r [0:127];
  logic [31:0] nr [0:127];

  function automatic logic [31:0] wmask_of(input logic [13:0] a);
    case (a)
      14'h0, 14'h1: return 32'h7;
      14'h4: return 32'h1BFF;
      14'h5: return 32'h3;
      14'hC: return 32'hFFFF_FFC0;
      14'h6, 14'h7, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [13:0] a);
    if (!(a inside {14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31, 14'h32, 14'h33,
                    14'h40, 14'h41, 14'h42})) return 32'h0;
    return r[a[6:0]] | ((a == 14'h0) ? 32'h8 : 32'h0);
  endfunction

  task automatic model_next();
    logic [31:0] m;
    logic fire, ticlr;
    fire = 0;
    ticlr = 0;
    nr = r;
    if (!resetn) begin
      foreach (nr[i]) nr[i] = 32'h0;
      nr[7'h42] = 32'hFFFF_FFFF;
      return;
    end
    nr[5][9:2] = hw_int_in;
    nr[5][12] = ipi_int_in;
    if (wb_ex) begin
      nr[1][2:0] = r[0][2:0];
      nr[0][2:0] = 3'd0;
      nr[6] = wb_pc;
      nr[5][21:16] = wb_ecode;
      nr[5][30:22] = wb_esubcode;
      if (wb_ecode == 6'h8) nr[7] = wb_pc;
      else if (wb_ecode == 6'h9) nr[7] = wb_vaddr;
    end else if (ertn_flush) begin
      nr[0][2:0] = r[1][2:0];
    end else if (csr_we) begin
      m = wmask_of(csr_num) & csr_wmask;
      if (m != 0) nr[csr_num[6:0]] = (r[csr_num[6:0]] & ~m) | (csr_wvalue & m);
      ticlr = csr_num == 14'h44 && csr_wmask[0] && csr_wvalue[0];
    end
    if (!wb_ex && !ertn_flush && csr_we && csr_num == 14'h41 && nr[7'h41][0])
      nr[7'h42] = nr[7'h41] & 32'hFFFF_FFFC;
    else if (r[7'h41][0] && r[7'h42] != 32'hFFFF_FFFF) begin
      if (r[7'h42] == 0) begin
        fire = 1;
        nr[7'h42] = r[7'h41][1] ? (r[7'h41] & 32'hFFFF_FFFC) : 32'hFFFF_FFFF;
      end else nr[7'h42] = r[7'h42] - 1;
    end
    if (fire) nr[5][11] = 1'b1;
    else if (ticlr) nr[5][11] = 1'b0;
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    r = nr;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_csr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
    csr_we = 1; csr_num = num; csr_wvalue = val; csr_wmask = mask;
    step();
    csr_we = 0;
  endtask

  task automatic rd_chk(input string name, input logic [13:0] num, input logic [31:0] exp,
                        input logic [31:0] msk = 32'hFFFF_FFFF);
    csr_re = 1; csr_num = num;
    #1;
    check(name, csr_rvalue & msk, exp);
    csr_re = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    step();
    step();
    resetn = 1;
  endtask

  typedef struct {
    logic [13:0] num;
    logic [31:0] val, mask, exp;
  } vec_t;
  vec_t vt [15];
  logic [13:0] addrs [16] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31, 14'h33,
                              14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h100};

  initial begin
    vt[0]  = '{14'h30, 32'hFFFF_FFFF, 32'h0000_FF00, 32'h0000_FF00};
    vt[1]  = '{14'hC,  32'h1C00_807F, 32'hFFFF_FFFF, 32'h1C00_8040};
    vt[2]  = '{14'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
    vt[3]  = '{14'h0,  32'h0000_0000, 32'h0000_0004, 32'h0000_000B};
    vt[4]  = '{14'h4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
    vt[5]  = '{14'h4,  32'h0000_0000, 32'h0000_0003, 32'h0000_1BFC};
    vt[6]  = '{14'h5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    vt[7]  = '{14'h5,  32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
    vt[8]  = '{14'h1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
    vt[9]  = '{14'h40, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505};
    vt[10] = '{14'h42, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[11] = '{14'h44, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vt[12] = '{14'h2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[13] = '{14'h33, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    vt[14] = '{14'h6,  32'hDEAD_BEEF, 32'hFFFF_0000, 32'hDEAD_0000};

    do_reset();
    #1;
    check("rst_rvalue", csr_rvalue, 32'h0);
    check("rst_ex_entry", ex_entry, 32'h0);
    check("rst_ertn_entry", ertn_entry, 32'h0);
    check("rst_has_int", {31'd0, has_int}, 32'h0);
    rd_chk("rst_crmd", 14'h0, 32'h8);
    rd_chk("rst_tval", 14'h42, 32'hFFFF_FFFF);
    rd_chk("rst_estat", 14'h5, 32'h0);

    foreach (vt[i]) begin
      wr_csr(vt[i].num, vt[i].val, vt[i].mask);
      rd_chk($sformatf("vec%0d", i), vt[i].num, vt[i].exp);
    end
    check("eentry_out", ex_entry, 32'h1C00_8040);

    do_reset();
    wr_csr(14'h0, 32'h7, 32'hFFFF_FFFF);
    wb_ex = 1; wb_ecode = 6'h9; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h0000_1003;
    step();
    wb_ex = 0;
    rd_chk("ex_crmd", 14'h0, 32'h8);
    rd_chk("ex_prmd", 14'h1, 32'h7);
    rd_chk("ex_era", 14'h6, 32'h1C00_0100);
    rd_chk("ex_badv", 14'h7, 32'h0000_1003);
    rd_chk("ex_ecode", 14'h5, 32'h0009_0000, 32'h003F_0000);
    check("ex_ertn_entry", ertn_entry, 32'h1C00_0100);

    ertn_flush = 1; csr_we = 1; csr_num = 14'h31; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF;
    step();
    ertn_flush = 0; csr_we = 0;
    rd_chk("ertn_crmd", 14'h0, 32'hF);
    rd_chk("ertn_save1", 14'h31, 32'h0);

    wr_csr(14'h41, 32'h9, 32'hFFFF_FFFF);
    for (int k = 0; k <= 8; k++) begin
      rd_chk($sformatf("oneshot_tval%0d", k), 14'h42, 32'(8 - k));
      if (k == 8) rd_chk("oneshot_is_early", 14'h5, 32'h0, 32'h800);
      step();
    end
    rd_chk("oneshot_is", 14'h5, 32'h800, 32'h800);
    rd_chk("oneshot_stop", 14'h42, 32'hFFFF_FFFF);
    step();
    rd_chk("oneshot_hold", 14'h42, 32'hFFFF_FFFF);
    wr_csr(14'h4, 32'h800, 32'hFFFF_FFFF);
    check("timer_has_int", {31'd0, has_int}, 32'h1);
    wr_csr(14'h44, 32'h1, 32'h1);
    check("ticlr_has_int", {31'd0, has_int}, 32'h0);
    rd_chk("ticlr_is", 14'h5, 32'h0, 32'h800);

    wr_csr(14'h41, 32'h7, 32'hFFFF_FFFF);
    for (int k = 0; k < 12; k++) begin
      rd_chk($sformatf("periodic_tval%0d", k), 14'h42, 32'(4 - k % 5));
      rd_chk($sformatf("periodic_is%0d", k), 14'h5, (k >= 5) ? 32'h800 : 32'h0, 32'h800);
      step();
    end

    do_reset();
    rd_chk("midrst_tval", 14'h42, 32'hFFFF_FFFF);
    rd_chk("midrst_estat", 14'h5, 32'h0);
    step();
    rd_chk("midrst_tval_hold", 14'h42, 32'hFFFF_FFFF);

    wr_csr(14'h4, 32'h4, 32'hFFFF_FFFF);
    wr_csr(14'h0, 32'h4, 32'h4);
    hw_int_in = 8'h01;
    #1;
    check("hw_not_yet", {31'd0, has_int}, 32'h0);
    step();
    check("hw_has_int", {31'd0, has_int}, 32'h1);
    rd_chk("hw_is", 14'h5, 32'h4, 32'h3FC);
    wr_csr(14'h0, 32'h0, 32'h4);
    check("hw_ie_off", {31'd0, has_int}, 32'h0);
    hw_int_in = 0;

    do_reset();
    for (int n = 0; n < 400; n++) begin
      csr_re = ($urandom % 4) != 0;
      csr_num = addrs[$urandom % 16];
      csr_we = ($urandom % 3) == 0;
      csr_wmask = $urandom;
      csr_wvalue = (csr_num == 14'h41) ? 32'($urandom_range(0, 15)) : $urandom;
      wb_ex = ($urandom % 12) == 0;
      ertn_flush = ($urandom % 12) == 0;
      wb_ecode = ($urandom % 3 == 0) ? 6'h8 : ($urandom % 2 == 0) ? 6'h9 : 6'($urandom);
      wb_esubcode = 9'($urandom);
      wb_pc = $urandom;
      wb_vaddr = $urandom;
      hw_int_in = 8'($urandom);
      ipi_int_in = ($urandom % 8) == 0;
      #1;
      check("rnd_rvalue", csr_rvalue, csr_re ? mread(csr_num) : 32'h0);
      check("rnd_ex_entry", ex_entry, r[12]);
      check("rnd_ertn_entry", ertn_entry, r[6]);
      check("rnd_has_int", {31'd0, has_int}, {31'd0, r[0][2] && |(r[5][12:0] & r[4][12:0])});
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_file.md
# csr_file

Control/status register file for the pipelined LoongArch CPU, answering the writeback stage's CSR port. It serves CSR reads and masked writes, records exception state on `wb_ex`, and restores privilege state on `ertn_flush`. It also runs the constant timer and drives the exception/return target PCs and the interrupt request sampled by the decode stage.

## Interface
- No parameters.
- `clk` in 1: clock.
- `resetn` in 1: reset; one clock; reset is synchronous and active-low.
- `csr_re` in 1: read qualifier.
- `csr_num` in 14: CSR address for read and write.
- `csr_rvalue` out 32: read data, combinational.
- `csr_we` in 1: write enable.
- `csr_wmask` in 32: per-bit write mask.
- `csr_wvalue` in 32: write data.
- `wb_ex` in 1: exception commit.
- `ertn_flush` in 1: ERTN commit.
- `wb_pc` in 32: PC of the committing instruction.
- `wb_ecode` in 6: exception code.
- `wb_esubcode` in 9: exception subcode.
- `wb_vaddr` in 32: faulting data address.
- `hw_int_in` in 8: external interrupt lines.
- `ipi_int_in` in 1: inter-processor interrupt.
- `ex_entry` out 32: EENTRY value.
- `ertn_entry` out 32: ERA value.
- `has_int` out 1: pending enabled interrupt.

## Operation
- **Write rule.** For every writable bit: `new = (old & ~wmask) | (wvalue & wmask)`. The write takes effect at the next edge when `csr_we=1`. Read-only and reserved bits ignore writes.
- **Read rule.** `csr_rvalue` = register selected by `csr_num` when `csr_re=1`. It reads 0 when `csr_re=0` or the address is unimplemented. A read returns pre-edge contents; there is no same-cycle write bypass.

**Registers** (address: fields, reset value):
- **CRMD 0x0**: PLV[1:0], IE[2] writable; DA[3] reads 1; all other bits read 0. Reset PLV=0, IE=0.
- **PRMD 0x1**: PPLV[1:0], PIE[2] writable. Reset 0.
- **ECFG 0x4**: LIE[9:0] and LIE[12:11] writable; bit10 reads 0. Reset 0.
- **ESTAT 0x5**:
  - IS[1:0] software-writable.
  - IS[9:2] is `hw_int_in` registered every cycle.
  - IS[10] reads 0.
  - IS[11] is the timer interrupt.
  - IS[12] is `ipi_int_in` registered.
  - Ecode[21:16] and EsubCode[30:22] are hardware-written only.
  - Reset all 0.
- **ERA 0x6**: all bits writable. Reset 0.
- **BADV 0x7**: all bits writable. Reset 0.
- **EENTRY 0xC**: VA[31:6] writable; [5:0] read 0. Reset 0.
- **SAVE0–3 0x30–0x33**: full 32 bits writable. Reset 0.
- **TID 0x40**: full 32 bits writable. Reset 0.
- **TCFG 0x41**: En[0], Periodic[1], InitVal[31:2] writable. Reset 0.
- **TVAL 0x42**: read-only. Reset 0xFFFF_FFFF.
- **TICLR 0x44**: reads 0. Writing 1 to bit0 (with mask bit0 set) clears IS[11].

**On `wb_ex`:**
- PRMD.PPLV ← CRMD.PLV and PRMD.PIE ← CRMD.IE.
- CRMD.PLV ← 0 and CRMD.IE ← 0.
- ERA ← `wb_pc`.
- ESTAT.Ecode ← `wb_ecode` and EsubCode ← `wb_esubcode`.
- Ecode 0x8 (ADEF): BADV ← `wb_pc`.
- Ecode 0x9 (ALE): BADV ← `wb_vaddr`.

**On `ertn_flush`:** CRMD.PLV ← PRMD.PPLV and CRMD.IE ← PRMD.PIE.

**Priority:**
- `wb_ex` and `ertn_flush` both suppress any `csr_we` in the same cycle; no register is software-written that cycle.
- If `wb_ex` and `ertn_flush` are both high, `wb_ex` wins.

**Timer (evaluated in priority order each cycle):**
1. A TCFG write whose resulting En=1 loads TVAL ← {new InitVal, 2'b00}.
2. Else, if En=1 and TVAL≠0xFFFF_FFFF:
   - If TVAL=0: set IS[11]. Then TVAL ← {InitVal, 2'b00} if Periodic, else TVAL ← 0xFFFF_FFFF (counting stops).
   - Otherwise TVAL ← TVAL−1.
3. Else TVAL holds.
- When a timer set and a TICLR clear hit IS[11] in the same cycle, the set wins.

**Outputs:**
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- `ex_entry` = EENTRY.
- `ertn_entry` = ERA.
- All three are combinational from registered state.

## Timing
- Reads have zero-cycle latency. Writes, exception updates and ERTN updates become visible in the cycle after the commit edge.
- `hw_int_in` / `ipi_int_in` → IS: 1 cycle. IS → `has_int`: 0 cycles.
- Timer: after a TCFG write with InitVal=N, En=1, TVAL reads 4N, counts down, and IS[11] is set at the edge after the cycle TVAL=0. That is N·4+1 edges after the write edge.
- Reset mid-operation clears all state to the reset values within one edge, including TVAL=0xFFFF_FFFF and IS=0.
- Output reset values:
  - `csr_rvalue` = 0 (`csr_re` low).
  - `ex_entry` = 0.
  - `ertn_entry` = 0.
  - `has_int` = 0.

## Test plan
- **Masked write:** write SAVE0 with wvalue 0xFFFF_FFFF, wmask 0x0000_FF00 → read returns 0x0000_FF00. Write EENTRY 0x1C00_807F, full mask → read returns 0x1C00_8040.
- **Exception entry:** CRMD.PLV=3, IE=1; `wb_ex`, ecode 0x9, `wb_pc`=0x1C00_0100, `wb_vaddr`=0x0000_1003 → next cycle:
  - CRMD[2:0]=0.
  - PRMD[2:0]=0b111.
  - ERA=0x1C00_0100.
  - BADV=0x0000_1003.
  - ESTAT[21:16]=0x9.
  - `ertn_entry`=0x1C00_0100.
- **ERTN restore:** following the above, `ertn_flush` → CRMD PLV=3, IE=1. In the same cycle, `csr_we` to SAVE1 is ignored.
- **One-shot timer:** TCFG ← InitVal 2, En=1, Periodic=0 → TVAL 8,7,…,0, then IS[11]=1 and TVAL=0xFFFF_FFFF and holds. With ECFG.LIE[11]=1 and CRMD.IE=1, `has_int`=1. Writing TICLR bit0 clears it the next cycle.
- **Periodic timer:** InitVal 1, Periodic=1 → TVAL 4→0→4 repeating; IS[11] is set at each wrap.
- **Hardware interrupt:** `hw_int_in`=0x01 with ECFG.LIE=0x004, CRMD.IE=1 → `has_int`=1 one cycle later. With IE=0, `has_int`=0.
